// File: rtl/car_collision.sv
// Round-robin car/frog collision arbiter: scans one car per clock, counts lives, flags game over.
// Optional post-hit invulnerability window is built only when COLLISION_INVULN_EN is defined.
module car_collision #(
  parameter int NUM_CARS      = 4,
  parameter int CAR_W         = 32,
  parameter int CAR_H         = 16,
  parameter int FROG_W        = 16,
  parameter int FROG_H        = 16,
  parameter int GAME_WIDTH    = 640,
  parameter int START_LIVES   = 3,
  parameter int INVULN_CYCLES = 25_000_000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [1:0]            game_state,
  input  logic [NUM_CARS*10-1:0] i_carX,
  input  logic [NUM_CARS*9-1:0]  i_carY,
  input  logic [9:0]            i_frogX,
  input  logic [8:0]            i_frogY,
  output logic                  o_Hit,
  output logic                  o_FrogReset,
  output logic [2:0]            o_Lives,
  output logic                  o_GameOver
);

  // state    | meaning
  // IDLE     | game not running, scan index parked at 0
  // SCAN     | testing car idx against the frog each cycle
  // COOLDOWN | invulnerable after a hit, counter runs while game runs
  // DEAD     | lives exhausted, held until reset
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SCAN     = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;
  localparam logic [1:0] DEAD     = 2'd3;

  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

  if (NUM_CARS < 1 || NUM_CARS > 16 || START_LIVES < 1 || START_LIVES > 7 ||
      INVULN_CYCLES < 1 || GAME_WIDTH > 2047) begin : g_bad_param
    $error("car_collision: parameter out of range");
  end

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             running;

  logic [9:0]  car_x_arr [NUM_CARS];
  logic [8:0]  car_y_arr [NUM_CARS];
  logic [10:0] cx, cy, fx, fy;
  logic [10:0] car_r, car_b, frog_r, frog_b;
  logic        y_ovl, x_dir, x_wrap, collide;

  always_comb begin
    for (int i = 0; i < NUM_CARS; i++) begin
      car_x_arr[i] = i_carX[10*i +: 10];
      car_y_arr[i] = i_carY[9*i +: 9];
    end
  end

  // All bounds are widened to 11 bits so right/bottom edges never wrap early
  assign cx     = {1'b0, car_x_arr[idx]};
  assign cy     = {2'b0, car_y_arr[idx]};
  assign fx     = {1'b0, i_frogX};
  assign fy     = {2'b0, i_frogY};
  assign car_r  = cx + 11'(CAR_W);
  assign car_b  = cy + 11'(CAR_H);
  assign frog_r = fx + 11'(FROG_W);
  assign frog_b = fy + 11'(FROG_H);

  assign y_ovl   = (fy < car_b) && (cy < frog_b);
  assign x_dir   = (fx < car_r) && (cx < frog_r);
  assign x_wrap  = (car_r > 11'(GAME_WIDTH)) && (fx < (car_r - 11'(GAME_WIDTH)));
  assign collide = y_ovl && (x_dir || x_wrap);

  assign running  = (game_state == 2'b01);
  assign idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;

`ifdef COLLISION_INVULN_EN
  localparam int CNT_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      idx         <= '0;
      o_Hit       <= 1'b0;
      o_FrogReset <= 1'b0;
      o_Lives     <= 3'(START_LIVES);
      o_GameOver  <= 1'b0;
`ifdef COLLISION_INVULN_EN
      cnt         <= '0;
`endif
    end else begin
      o_Hit       <= 1'b0;
      o_FrogReset <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          if (running) state <= SCAN;
        end
        SCAN: begin
          if (!running) begin
            state <= IDLE;
          end else if (collide) begin
            o_Hit       <= 1'b1;
            o_FrogReset <= 1'b1;
            if (o_Lives != 3'd0) o_Lives <= o_Lives - 3'd1;
            if (o_Lives <= 3'd1) begin
              state      <= DEAD;
              o_GameOver <= 1'b1;
            end else begin
`ifdef COLLISION_INVULN_EN
              state <= COOLDOWN;
              cnt   <= CNT_W'(INVULN_CYCLES - 1);
`else
              idx   <= idx_next;
`endif
            end
          end else begin
            idx <= idx_next;
          end
        end
`ifdef COLLISION_INVULN_EN
        COOLDOWN: begin
          if (cnt == '0) begin
            state <= SCAN;
            idx   <= '0;
          end else if (running) begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        DEAD: begin
          o_GameOver <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
